// File: rtl/add_char_clk_if.sv
// Sequencer-facing bus of the ADD/CHAR helper: start strobes and operands in,
// stop strobes, results and flags out.
interface add_char_clk_if;
  logic        add_start;
  logic [30:0] add_in1;
  logic [30:0] add_in2;
  logic        add_stop;
  logic [30:0] add_out;
  logic        add_overflow;
  logic        char_start;
  logic [29:0] char_in;
  logic        char_stop;
  logic [59:0] char_out;

  modport master (
    output add_start, add_in1, add_in2, char_start, char_in,
    input  add_stop, add_out, add_overflow, char_stop, char_out
  );

  modport slave (
    input  add_start, add_in1, add_in2, char_start, char_in,
    output add_stop, add_out, add_overflow, char_stop, char_out
  );
endinterface

// File: rtl/add_char_clk.sv
// MIX-1009 helper: reset stretcher with go pulse, single-cycle sign-magnitude
// ADD, and a 31-cycle double-dabble CHAR (binary -> ten character digits).
module add_char_clk #(
  parameter int unsigned RST_STRETCH = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  output logic          sys_reset_o,
  output logic          go_o,
  add_char_clk_if.slave bus
);
  localparam int unsigned CW = (RST_STRETCH < 1) ? 1 : $clog2(RST_STRETCH + 1);
  localparam int unsigned NDIG = 10;

  // ---------------- reset stretcher ----------------
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          sysrst_q;

  always_comb begin
    rcnt_d = rcnt_q;
    if (rcnt_q != '0) rcnt_d = rcnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rcnt_q   <= CW'(RST_STRETCH);
      sysrst_q <= 1'b1;
    end else begin
      rcnt_q   <= rcnt_d;
      sysrst_q <= sys_reset_o;
    end
  end

  assign sys_reset_o = reset_i | (rcnt_q != '0);
  // High only on the first low cycle after a high one.
  assign go_o        = sysrst_q & ~sys_reset_o;

  // ---------------- ADD ----------------
  logic        add_stop_q;
  logic [29:0] m1, m2, diff;
  logic [30:0] sum;
  logic        s1, s2, m1_ge;

  always_comb begin
    m1    = bus.add_in1[29:0];
    m2    = bus.add_in2[29:0];
    s1    = bus.add_in1[30];
    s2    = bus.add_in2[30];
    sum   = {1'b0, m1} + {1'b0, m2};
    m1_ge = (m1 >= m2);
    diff  = m1_ge ? (m1 - m2) : (m2 - m1);
    if (s1 == s2) begin
      bus.add_out      = {s1, sum[29:0]};
      bus.add_overflow = sum[30];
    end else begin
      // Ties keep in1's sign, giving -0 for (-x)+(+x).
      bus.add_out      = {m1_ge ? s1 : s2, diff};
      bus.add_overflow = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) add_stop_q <= 1'b0;
    else         add_stop_q <= bus.add_start;
  end

  assign bus.add_stop = add_stop_q;

  // ---------------- CHAR ----------------
  typedef enum logic {C_IDLE, C_BUSY} cstate_e;

  cstate_e            cst_q, cst_d;
  logic [29:0]        sh_q, sh_d;
  logic [4*NDIG-1:0]  bcd_q, bcd_d, bcd_adj, bcd_nxt;
  logic [4:0]         it_q, it_d;
  logic [6*NDIG-1:0]  cout_q, cout_d, codes;
  logic               cstop_q, cstop_d;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign bcd_adj[g*4 +: 4] = (bcd_q[g*4 +: 4] >= 4'd5) ? bcd_q[g*4 +: 4] + 4'd3
                                                         : bcd_q[g*4 +: 4];
    assign codes[g*6 +: 6]   = 6'd30 + {2'b00, bcd_nxt[g*4 +: 4]};
  end

  // Top adjusted bit falls off: 30-bit inputs never need an 11th digit.
  assign bcd_nxt = (4*NDIG)'({bcd_adj, sh_q[29]});

  always_comb begin
    cst_d   = cst_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    it_d    = it_q;
    cout_d  = cout_q;
    cstop_d = 1'b0;
    case (cst_q)
      C_IDLE: begin
        if (bus.char_start) begin
          sh_d  = bus.char_in;
          bcd_d = '0;
          it_d  = '0;
          cst_d = C_BUSY;
        end
      end
      C_BUSY: begin
        sh_d  = sh_q << 1;
        bcd_d = bcd_nxt;
        it_d  = it_q + 5'd1;
        if (it_q == 5'd29) begin
          cout_d  = codes;
          cstop_d = 1'b1;
          cst_d   = C_IDLE;
        end
      end
      default: cst_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cst_q   <= C_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      it_q    <= '0;
      cout_q  <= '0;
      cstop_q <= 1'b0;
    end else begin
      cst_q   <= cst_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      it_q    <= it_d;
      cout_q  <= cout_d;
      cstop_q <= cstop_d;
    end
  end

  assign bus.char_stop = cstop_q;
  assign bus.char_out  = cout_q;
endmodule

// File: tb/tb_add_char_clk.sv
// Randomized bench for add_char_clk against an arithmetic reference model,
// with directed cases pinning both the model and the DUT.
module tb_add_char_clk;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sys_reset, go;

  add_char_clk_if bus();

  add_char_clk #(.RST_STRETCH(16)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .sys_reset_o(sys_reset),
    .go_o       (go),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int last_rst = 0;

  // reference model state
  logic        m_add_stop = 1'b0;
  logic        m_char_stop = 1'b0;
  logic [59:0] m_char_out = '0;
  bit          m_busy = 1'b0;
  int          m_left = 0;
  logic [29:0] m_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  // MIX ADD via signed integer arithmetic: returns {overflow, sign, magnitude}.
  function automatic logic [31:0] add_ref(input logic [30:0] a, input logic [30:0] b);
    longint va, vb, s, mag;
    logic   sg;
    va = longint'(a[29:0]); if (a[30]) va = -va;
    vb = longint'(b[29:0]); if (b[30]) vb = -vb;
    s   = va + vb;
    mag = (s < 0) ? -s : s;
    sg  = (s < 0) ? 1'b1 : (s > 0) ? 1'b0 : a[30];
    return {(mag >= 64'(1) << 30), sg, 30'(mag % (64'(1) << 30))};
  endfunction

  // Decimal digits via div/mod, each mapped to code 30+d, LSB digit lowest.
  function automatic logic [59:0] char_ref(input logic [29:0] v);
    logic [59:0] r;
    int unsigned x;
    x = v;
    for (int i = 0; i < 10; i++) begin
      r[6*i +: 6] = 6'(30 + x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_add_stop = 1'b0; m_char_stop = 1'b0; m_char_out = '0; m_busy = 1'b0;
    end else begin
      m_add_stop  = bus.add_start;
      m_char_stop = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_char_stop = 1'b1; m_char_out = char_ref(m_val);
        end
      end else if (bus.char_start) begin
        m_busy = 1'b1; m_left = 30; m_val = bus.char_in;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (reset) last_rst = cyc;
      chk("sys_reset", 64'(sys_reset), 64'(reset || (cyc - last_rst <= 16)));
      chk("go", 64'(go), 64'(!reset && (cyc - last_rst == 17)));
      chk("add_stop", 64'(bus.add_stop), 64'(m_add_stop));
      chk("char_stop", 64'(bus.char_stop), 64'(m_char_stop));
      chk("char_out", 64'(bus.char_out), 64'(m_char_out));
      if (m_add_stop)
        chk("add_result", 64'({bus.add_overflow, bus.add_out}),
            64'(add_ref(bus.add_in1, bus.add_in2)));
    end
  end

  task automatic do_add(input logic [30:0] a, input logic [30:0] b,
                        input logic [30:0] eo, input logic eov);
    chk("add_model", 64'(add_ref(a, b)), 64'({eov, eo}));
    @(posedge clk); #1;
    bus.add_start = 1'b1; bus.add_in1 = a; bus.add_in2 = b;
    @(posedge clk); #1;
    bus.add_start = 1'b0;
    @(negedge clk);
    chk("add_dir_stop", 64'(bus.add_stop), 64'(1));
    chk("add_dir_out", 64'(bus.add_out), 64'(eo));
    chk("add_dir_ovf", 64'(bus.add_overflow), 64'(eov));
  endtask

  task automatic do_char(input logic [29:0] v, input logic [59:0] exp);
    chk("char_model", 64'(char_ref(v)), 64'(exp));
    @(posedge clk); #1;
    bus.char_start = 1'b1; bus.char_in = v;
    @(posedge clk); #1;
    bus.char_start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("char_dir_stop", 64'(bus.char_stop), 64'(1));
    chk("char_dir_out", 64'(bus.char_out), 64'(exp));
  endtask

  function automatic logic [30:0] rand_word(input logic [30:0] other);
    logic [30:0] w;
    w = 31'($urandom);
    case ($urandom_range(0, 3))
      0: ;
      1: w[29:0] = 30'h3FFF_FFFF - 30'($urandom_range(0, 3));
      2: w[29:0] = 30'($urandom_range(0, 20));
      default: w[29:0] = other[29:0];
    endcase
    return w;
  endfunction

  localparam logic [30:0] MAXM = {1'b0, 30'h3FFF_FFFF};

  initial begin
    bus.add_start = 1'b0; bus.add_in1 = '0; bus.add_in2 = '0;
    bus.char_start = 1'b0; bus.char_in = '0;

    // reset held 3 cycles, then the stretch and go
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("stretch_high", 64'(sys_reset), 64'(1));
      chk("stretch_nogo", 64'(go), 64'(0));
    end
    @(negedge clk);
    chk("go_pulse", 64'(go), 64'(1));
    chk("sysrst_low", 64'(sys_reset), 64'(0));
    @(negedge clk);
    chk("go_once", 64'(go), 64'(0));

    do_add(31'd100, 31'd23, 31'd123, 1'b0);
    do_add(31'd5, {1'b1, 30'd9}, {1'b1, 30'd4}, 1'b0);
    do_add({1'b1, 30'd7}, 31'd7, {1'b1, 30'd0}, 1'b0);
    do_add(MAXM, 31'd2, 31'd1, 1'b1);
    do_add({1'b1, MAXM[29:0]}, {1'b1, 30'd1}, {1'b1, 30'd0}, 1'b1);

    do_char(30'd12977699, {6'd30, 6'd30, 6'd31, 6'd32, 6'd39, 6'd37, 6'd37, 6'd36, 6'd39, 6'd39});
    do_char(30'd0, {10{6'd30}});
    do_char(30'd1073741823, {6'd31, 6'd30, 6'd37, 6'd33, 6'd37, 6'd34, 6'd31, 6'd38, 6'd32, 6'd33});

    // second start while busy is ignored
    @(posedge clk); #1;
    bus.char_start = 1'b1; bus.char_in = 30'd4321;
    @(posedge clk); #1;
    bus.char_start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.char_start = 1'b1; bus.char_in = 30'd999;
    @(posedge clk); #1;
    bus.char_start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("busy_ign_stop", 64'(bus.char_stop), 64'(1));
    chk("busy_ign_out", 64'(bus.char_out),
        64'({6'd30, 6'd30, 6'd30, 6'd30, 6'd30, 6'd30, 6'd34, 6'd33, 6'd32, 6'd31}));

    // reset mid-conversion aborts it
    @(posedge clk); #1;
    bus.char_start = 1'b1; bus.char_in = 30'd55555;
    @(posedge clk); #1;
    bus.char_start = 1'b0;
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out", 64'(bus.char_out), 64'(0));
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("abort_nostop", 64'(bus.char_stop), 64'(0));
    end

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset          = ($urandom_range(0, 499) == 0);
      bus.add_start  = ($urandom_range(0, 2) == 0);
      bus.add_in1    = rand_word(bus.add_in2);
      bus.add_in2    = rand_word(bus.add_in1);
      bus.char_start = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       bus.char_in = '0;
        1:       bus.char_in = 30'h3FFF_FFFF;
        default: bus.char_in = 30'($urandom);
      endcase
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.add_start = 1'b0; bus.char_start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/add_char_clk.md
# add_char_clk

Arithmetic/conversion helper block for the MIX-1009 core. It bundles three functions. First, a reset stretcher that produces the core's system reset and a one-shot "go" pulse. Second, a single-cycle MIX ADD unit on 31-bit sign-magnitude words. Third, a multi-cycle CHAR unit that converts a 30-bit binary magnitude into ten MIX character-coded decimal digits. The instruction sequencer drives the start strobes and consumes the stop strobes, results and flags.

## Interface
Parameters:
- RST_STRETCH, 16: cycles `sys_reset` stays high after `reset` falls (and after configuration).

Ports:
- `clk`  in  1  single system clock; all state on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sys_reset`  out  1  stretched system reset for the core.
- `go`  out  1  one-cycle pulse on the first cycle after `sys_reset` falls.
- `add_start`  in  1  ADD request strobe (one cycle).
- `add_in1`  in  31  augend (register A): bit 30 sign (1 = negative), bits 29:0 magnitude.
- `add_in2`  in  31  addend (field-extracted operand), same format.
- `add_stop`  out  1  ADD result valid strobe.
- `add_out`  out  31  sum.
- `add_overflow`  out  1  overflow flag for the sum.
- `char_start`  in  1  CHAR request strobe.
- `char_in`  in  30  binary magnitude to convert.
- `char_stop`  out  1  CHAR done strobe.
- `char_out`  out  60  ten 6-bit character codes; bits 59:54 hold the most significant digit.

## Operation
Reset stretcher:
- A down-counter is loaded with RST_STRETCH at configuration and on every cycle `reset` is high.
- `sys_reset` = `reset` OR (counter ≠ 0). The counter decrements while non-zero.
- `go` is high exactly on the first cycle after `sys_reset` falls. It stays low while `sys_reset` is high.

ADD (MIX sign-magnitude):
- Same signs: magnitude = |in1| + |in2|; sign = sign of in1.
- Different signs: magnitude = larger − smaller; sign = sign of the operand with the larger magnitude.
- Equal magnitudes with different signs: result magnitude is 0 and the sign is the sign of in1.
- If the true magnitude is ≥ 2^30: `add_out` magnitude = sum mod 2^30 and `add_overflow` = 1. Otherwise `add_overflow` = 0.
- `add_out` and `add_overflow` are combinational from `add_in1`/`add_in2`. They are meaningful only while `add_stop` = 1.
- The caller holds the inputs valid during the stop cycle.

CHAR:
- On `char_start` while idle: capture `char_in` and clear the BCD accumulator. The unit then becomes busy.
- Busy: double-dabble runs one bit per cycle, MSB first, for 30 iterations. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts in the next bit.
- After iteration 30, each digit d is mapped to code 30+d. The result is loaded into `char_out` and the unit returns to idle.
- `char_out` holds its value until the next completion.
- `char_start` while busy is ignored.
- Leading zeros are emitted as code 30. No blanking.

## Timing
- Reset values: `sys_reset` = 1, `go` = 0, `add_stop` = 0, `char_stop` = 0, `char_out` = 0, CHAR idle.
- `reset` mid-CHAR aborts the conversion. No `char_stop` is produced.
- `add_stop` is `add_start` registered: 1-cycle latency, 1-cycle pulse. Back-to-back starts give back-to-back stops.
- `char_stop` pulses for one cycle exactly 31 cycles after the `char_start` cycle. The cycle after the stop, the unit accepts a new start.
- `go` occurs RST_STRETCH+1 cycles after the last cycle with `reset` high.
- ADD and CHAR are independent and may be active simultaneously.

## Test plan
- Reset: hold `reset` 3 cycles, then release. Required: `sys_reset` stays high 16 more cycles; `go` pulses once on the next cycle; both stop strobes stay low throughout.
- ADD, same sign: in1 = +100, in2 = +23 → on the cycle after start, `add_stop` = 1, out = +123, overflow = 0.
- ADD, mixed signs: in1 = +5, in2 = −9 → out = −4, overflow = 0. Also in1 = −7, in2 = +7 → out = −0 (bit 30 = 1, magnitude 0).
- ADD overflow: in1 = +(2^30 − 1), in2 = +2 → out = +1, overflow = 1. Also in1 = −(2^30 − 1), in2 = −1 → out = −0, overflow = 1.
- CHAR: in = 12977699 → `char_stop` 31 cycles after start; digit codes MSB→LSB = 30,30,31,32,39,37,37,36,39,39. Also in = 0 → all ten codes are 30. Also in = 1073741823 → 31,30,37,33,37,34,31,38,32,33.
- CHAR robustness: a second `char_start` at cycle +10 is ignored (single stop at +31 with the first result). `reset` at cycle +15 produces no stop and `char_out` = 0.
